// File: rtl/lsu_pkg.sv
// Shared encodings for the Wishbone load/store master.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUS,
      S_GAP,
      S_RESP
   } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for stores, misalign detection, load extract and extend.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lo,
   input  logic [31:0] wdata,
   output logic [3:0]  sel,
   output logic [31:0] wdat,
   output logic        misalign,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_lo,
   input  logic        ld_uns,
   input  logic [31:0] rdata,
   output logic [31:0] ldat
);

   logic [31:0] sh;

   always_comb begin
      sel      = '0;
      wdat     = '0;
      misalign = 1'b0;
      unique case (size)
         SZ_BYTE: begin
            sel  = 4'b0001 << lo;
            wdat = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            sel      = lo[1] ? 4'b1100 : 4'b0011;
            wdat     = {2{wdata[15:0]}};
            misalign = lo[0];
         end
         SZ_WORD: begin
            sel      = 4'b1111;
            wdat     = wdata;
            misalign = |lo;
         end
         default: misalign = 1'b1;
      endcase
   end

   always_comb begin
      sh   = rdata >> {ld_lo, 3'b000};
      ldat = sh;
      unique case (ld_size)
         SZ_BYTE: ldat = {{24{~ld_uns & sh[7]}}, sh[7:0]};
         SZ_HALF: ldat = {{16{~ld_uns & sh[15]}}, sh[15:0]};
         default: ldat = sh;
      endcase
   end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic master: one single READ/WRITE cycle per CPU request,
// with retry, timeout and error folded into a one-cycle response pulse.
module wb_lsu_master
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_unsigned_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        resp_valid_o,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        cyc_o,
   output logic        stb_o,
   output logic        we_o,
   output logic [31:0] adr_o,
   output logic [3:0]  sel_o,
   output logic [31:0] dat_o,
   input  logic [31:0] dat_i,
   input  logic        ack_i,
   input  logic        err_i,
   input  logic        rty_i
);

   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRY + 1);

   state_t        state, state_n;
   logic [WW-1:0] wait_cnt, wait_n;
   logic [RW-1:0] retry_cnt, retry_n;
   logic [1:0]    ld_size, ld_lo;
   logic          ld_uns;
   logic [3:0]    sel;
   logic [31:0]   wdat, ldat, rdata_n;
   logic          misalign, accept, err_n;

   lsu_align u_align (
      .size     (req_size_i),
      .lo       (req_addr_i[1:0]),
      .wdata    (req_wdata_i),
      .sel      (sel),
      .wdat     (wdat),
      .misalign (misalign),
      .ld_size  (ld_size),
      .ld_lo    (ld_lo),
      .ld_uns   (ld_uns),
      .rdata    (dat_i),
      .ldat     (ldat)
   );

   assign req_ready_o = (state == S_IDLE);
   assign accept      = req_valid_i & req_ready_o;

   always_comb begin
      state_n = state;
      wait_n  = wait_cnt;
      retry_n = retry_cnt;
      err_n   = 1'b0;
      rdata_n = '0;
      unique case (state)
         S_IDLE: begin
            if (accept) begin
               wait_n  = '0;
               retry_n = '0;
               if (misalign) begin
                  state_n = S_RESP;
                  err_n   = 1'b1;
               end else begin
                  state_n = S_BUS;
               end
            end
         end
         S_BUS: begin
            // err beats ack beats rty when several arrive together
            priority case (1'b1)
               err_i: begin
                  state_n = S_RESP;
                  err_n   = 1'b1;
               end
               ack_i: begin
                  state_n = S_RESP;
                  rdata_n = we_o ? '0 : ldat;
               end
               rty_i: begin
                  if (retry_cnt == RW'(MAX_RETRY)) begin
                     state_n = S_RESP;
                     err_n   = 1'b1;
                  end else begin
                     retry_n = retry_cnt + RW'(1);
                     state_n = S_GAP;
                  end
               end
               default: begin
                  if (wait_cnt == WW'(TIMEOUT_CYCLES - 1)) begin
                     state_n = S_RESP;
                     err_n   = 1'b1;
                  end else begin
                     wait_n = wait_cnt + WW'(1);
                  end
               end
            endcase
         end
         S_GAP: begin
            state_n = S_BUS;
            wait_n  = '0;
         end
         S_RESP:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state        <= S_IDLE;
         wait_cnt     <= '0;
         retry_cnt    <= '0;
         cyc_o        <= 1'b0;
         stb_o        <= 1'b0;
         we_o         <= 1'b0;
         adr_o        <= '0;
         sel_o        <= '0;
         dat_o        <= '0;
         ld_size      <= '0;
         ld_lo        <= '0;
         ld_uns       <= 1'b0;
         resp_valid_o <= 1'b0;
         resp_err_o   <= 1'b0;
         resp_rdata_o <= '0;
      end else begin
         state        <= state_n;
         wait_cnt     <= wait_n;
         retry_cnt    <= retry_n;
         cyc_o        <= (state_n == S_BUS);
         stb_o        <= (state_n == S_BUS);
         resp_valid_o <= (state_n == S_RESP);
         resp_err_o   <= (state_n == S_RESP) & err_n;
         resp_rdata_o <= rdata_n;
         if (accept && !misalign) begin
            adr_o   <= {req_addr_i[31:2], 2'b00};
            sel_o   <= sel;
            dat_o   <= wdat;
            we_o    <= req_we_i;
            ld_size <= req_size_i;
            ld_lo   <= req_addr_i[1:0];
            ld_uns  <= req_unsigned_i;
         end
      end
   end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Directed bench: master paired with a one-wait memory slave and
// a retry/silent stub mode for the error paths.
module tb_wb_lsu_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_uns = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        cyc, stb, we;
   logic [31:0] adr, dat_o;
   logic [3:0]  sel;
   logic [31:0] dat_i = '0;
   logic        ack = 1'b0, err = 1'b0, rty = 1'b0;

   int checks = 0;
   int errors = 0;

   // 0: memory, 1: rty rty_limit times then ack, 2: silent
   int mode = 0;
   int rty_limit = 0;
   int rty_cnt = 0;
   logic [31:0] mem [0:15];

   int n_cyc, n_stb, n_gap, lat;
   logic cyc_at_resp;
   logic [3:0] last_sel;
   logic [31:0] last_dat;
   logic [31:0] rd;
   logic        re;

   wb_lsu_master dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_we_i       (req_we),
      .req_size_i     (req_size),
      .req_unsigned_i (req_uns),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .resp_valid_o   (resp_valid),
      .resp_rdata_o   (resp_rdata),
      .resp_err_o     (resp_err),
      .cyc_o          (cyc),
      .stb_o          (stb),
      .we_o           (we),
      .adr_o          (adr),
      .sel_o          (sel),
      .dat_o          (dat_o),
      .dat_i          (dat_i),
      .ack_i          (ack),
      .err_i          (err),
      .rty_i          (rty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      ack <= 1'b0;
      rty <= 1'b0;
      err <= 1'b0;
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
         rty_cnt <= 0;
      end else if (req_ready) begin
         rty_cnt <= 0;
      end else if (cyc && stb && !ack && !rty && !err) begin
         if (mode == 1 && rty_cnt < rty_limit) begin
            rty     <= 1'b1;
            rty_cnt <= rty_cnt + 1;
         end else if (mode != 2) begin
            ack   <= 1'b1;
            dat_i <= mem[adr[5:2]];
            if (we)
               for (int b = 0; b < 4; b++)
                  if (sel[b]) mem[adr[5:2]][8*b +: 8] <= dat_o[8*b +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic run(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rdata, output logic rerr);
      logic got;
      @(negedge clk);
      req_we    = w;
      req_size  = sz;
      req_uns   = u;
      req_addr  = a;
      req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      got = 1'b0;
      rdata = '0;
      rerr = 1'b0;
      lat = 0;
      n_cyc = 0;
      n_stb = 0;
      n_gap = 0;
      cyc_at_resp = 1'b0;
      for (int i = 1; i <= 200 && !got; i++) begin
         @(negedge clk);
         if (cyc) begin
            n_cyc++;
            last_sel = sel;
            last_dat = dat_o;
         end
         if (stb) n_stb++;
         if (resp_valid) begin
            got = 1'b1;
            lat = i;
            rdata = resp_rdata;
            rerr = resp_err;
            cyc_at_resp = cyc;
         end else if (!cyc && !req_ready) begin
            n_gap++;
         end
      end
      check("resp_seen", {31'd0, got}, 32'd1);
   endtask

   initial begin
      logic seen;
      #12;
      check("rst_ready", {31'd0, req_ready}, 32'd1);
      check("rst_cyc", {30'd0, cyc, stb}, 32'd0);
      check("rst_resp", {31'd0, resp_valid}, 32'd0);
      check("rst_sel_adr", {28'd0, sel} | adr, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run(1'b1, 2'b10, 1'b0, 32'h0, 32'h01234567, rd, re);
      check("sw_sel", {28'd0, last_sel}, 32'hF);
      check("sw_err", {31'd0, re}, 32'd0);
      run(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, re);
      check("lw_data", rd, 32'h01234567);
      check("lw_lat", lat, 32'd3);
      check("lw_cyc_drop", {31'd0, cyc_at_resp}, 32'd0);

      run(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, rd, re);
      check("lb0", rd, 32'h00000067);
      run(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, rd, re);
      check("lb1", rd, 32'h00000045);
      run(1'b0, 2'b00, 1'b0, 32'h2, 32'h0, rd, re);
      check("lb2", rd, 32'h00000023);
      run(1'b0, 2'b00, 1'b0, 32'h3, 32'h0, rd, re);
      check("lb3", rd, 32'h00000001);
      run(1'b1, 2'b00, 1'b0, 32'h1, 32'h80, rd, re);
      check("sb_sel", {28'd0, last_sel}, 32'h2);
      check("sb_dat", last_dat, 32'h80808080);
      run(1'b0, 2'b00, 1'b0, 32'h1, 32'h0, rd, re);
      check("lb_sext", rd, 32'hFFFFFF80);
      run(1'b0, 2'b00, 1'b1, 32'h1, 32'h0, rd, re);
      check("lbu", rd, 32'h00000080);

      run(1'b1, 2'b01, 1'b0, 32'h2, 32'hBEEF, rd, re);
      check("sh_sel", {28'd0, last_sel}, 32'hC);
      check("sh_dat", last_dat, 32'hBEEFBEEF);
      run(1'b0, 2'b01, 1'b0, 32'h2, 32'h0, rd, re);
      check("lh_sext", rd, 32'hFFFFBEEF);
      run(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, re);
      check("lw_merged", rd, 32'hBEEF8067);

      run(1'b0, 2'b10, 1'b0, 32'h1, 32'h0, rd, re);
      check("mis_err", {31'd0, re}, 32'd1);
      check("mis_lat", lat, 32'd1);
      check("mis_nocyc", n_cyc, 32'd0);
      check("mis_rdata", rd, 32'd0);
      run(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, rd, re);
      check("sz11_err", {31'd0, re}, 32'd1);
      check("sz11_nocyc", n_cyc, 32'd0);

      mode = 1;
      rty_limit = 3;
      run(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, re);
      check("rty3_err", {31'd0, re}, 32'd0);
      check("rty3_gaps", n_gap, 32'd3);
      check("rty3_data", rd, 32'hBEEF8067);
      rty_limit = 4;
      run(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, re);
      check("rty4_err", {31'd0, re}, 32'd1);
      check("rty4_gaps", n_gap, 32'd3);
      mode = 2;
      run(1'b0, 2'b10, 1'b0, 32'h0, 32'h0, rd, re);
      check("tmo_err", {31'd0, re}, 32'd1);
      check("tmo_stb", n_stb, 32'd16);

      @(negedge clk);
      req_we = 1'b0;
      req_size = 2'b10;
      req_addr = 32'h0;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_cyc", {31'd0, cyc}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_cyc", {30'd0, cyc, stb}, 32'd0);
      seen = 1'b0;
      repeat (2) @(negedge clk) seen |= resp_valid;
      rst_n = 1'b1;
      repeat (5) @(negedge clk) seen |= resp_valid;
      check("rst_no_resp", {31'd0, seen}, 32'd0);
      check("rst_ready_after", {31'd0, req_ready}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
